// File: rtl/toggle_bank_arbiter.sv
// toggle_bank_arbiter
//   Shares one W-bit bank of toggle flip-flops between N requesters. A
//   round-robin arbiter picks one winner per operation. The winner's mask is
//   latched at the granting edge and applied as the bank's T inputs for
//   exactly one clock (the APPLY cycle).
//
//   Build option: define TOGGLE_BANK_ARB_FIXED_PRIO_EN to get fixed priority
//   instead of round-robin. In that build the lowest index wins and the
//   pointer is not built.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   en         arbitration enable (an operation already in APPLY still completes)
//   req[N]     request vector, bit i = requester i
//   mask[N*W]  toggle masks, requester i at [i*W +: W]
//   gnt[N]     registered one-hot grant, high during the APPLY cycle
//   q[W]       toggle bank state
//   done       one-cycle pulse after each bank update
//   apply_cnt  16-bit count of applied operations, wraps

// One toggle flip-flop of the bank.
module toggle_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)    q <= 1'b0;
    else if (t) q <= ~q;
  end
endmodule

module toggle_bank_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] mask,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           done,
  output logic [15:0]    apply_cnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, APPLY} state_t;

  state_t         state, state_nxt;
  logic           grant_go;
  logic [PW-1:0]  win;
  logic [N-1:0]   win_oh;
  logic [W-1:0]   mask_lat;
  logic [W-1:0]   t_vec;

  // ---------------------------------------------------------------------
  // Winner select
  // ---------------------------------------------------------------------
`ifdef TOGGLE_BANK_ARB_FIXED_PRIO_EN
  // Lowest set index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) win = PW'(i);
  end
`else
  logic [PW-1:0] ptr;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;
  logic          found;

  // First set request at or above ptr, wrapping modulo N. sum never exceeds
  // 2N-2, so one conditional subtract is a full modulo.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      cand = sum[PW-1:0];
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           ptr <= '0;
    else if (grant_go) ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
  end
`endif

  assign win_oh = {{(N-1){1'b0}}, 1'b1} << win;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    grant_go  = 1'b0;
    case (state)
      IDLE: begin
        if (en && (|req)) begin
          grant_go  = 1'b1;
          state_nxt = APPLY;
        end
      end
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= 1'b0;
      apply_cnt <= '0;
      mask_lat  <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= grant_go ? win_oh : '0;
      // done follows the APPLY cycle, so it can never overlap gnt.
      done  <= (state == APPLY);
      if (grant_go)        mask_lat  <= mask[win*W +: W];
      if (state == APPLY)  apply_cnt <= apply_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Toggle bank: T inputs are live only during APPLY
  // ---------------------------------------------------------------------
  assign t_vec = (state == APPLY) ? mask_lat : '0;

  for (genvar b = 0; b < W; b++) begin : g_bank
    toggle_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[b]),
      .q   (q[b])
    );
  end

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// Directed bench for toggle_bank_arbiter (N=4, W=8). A transaction-level
// model tracks bank contents, counter, grant and done from the arbitration
// rules and is compared with the DUT every cycle; directed checks pin the
// hand-computed values of each scenario.
module tb_toggle_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, en;
  logic [N-1:0]   req;
  logic [N*W-1:0] mask;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           done;
  logic [15:0]    apply_cnt;

  toggle_bank_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask),
    .gnt(gnt), .q(q), .done(done), .apply_cnt(apply_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [W-1:0] m_q, m_lat;
  logic [N-1:0] m_gnt;
  logic         m_done;
  logic [15:0]  m_cnt;
  int           m_ptr;
  bit           m_pending;   // an operation has been granted, bank not yet updated

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef TOGGLE_BANK_ARB_FIXED_PRIO_EN
    p = 0;
`endif
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  initial begin
    int w;
    m_q = '0; m_lat = '0; m_gnt = '0; m_done = 1'b0; m_cnt = '0;
    m_ptr = 0; m_pending = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_q = '0; m_lat = '0; m_gnt = '0; m_done = 1'b0; m_cnt = '0;
        m_ptr = 0; m_pending = 1'b0;
      end else if (m_pending) begin
        m_q = m_q ^ m_lat;
        m_cnt = m_cnt + 16'd1;
        m_gnt = '0;
        m_done = 1'b1;
        m_pending = 1'b0;
      end else begin
        m_done = 1'b0;
        m_gnt = '0;
        if (en && req != '0) begin
          w = pick(req, m_ptr);
          m_gnt = N'(1) << w;
          m_lat = mask[w*W +: W];
          m_ptr = (w + 1) % N;
          m_pending = 1'b1;
        end
      end
      #2;
      if (chk_on) begin
        chk("model_gnt", gnt, m_gnt);
        chk("model_q", q, m_q);
        chk("model_done", done, m_done);
        chk("model_cnt", apply_cnt, m_cnt);
        chk("gnt_done_excl", (gnt != '0) && done, 1'b0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Issue one operation from requester idx; returns at the negedge after the
  // bank update, when done is expected high.
  task automatic do_op(input int idx, input logic [W-1:0] m);
    bit ok;
    @(negedge clk);
    req = N'(1) << idx;
    mask[idx*W +: W] = m;
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (gnt != '0) begin ok = 1'b1; break; end
    end
    chk("grant_seen", ok, 1'b1);
    chk("grant_who", gnt, N'(1) << idx);
    req = '0;
    @(negedge clk);
  endtask

  // Hold req_v and collect n grants; returns index order and spacing.
  task automatic collect(input logic [N-1:0] req_v, input int n,
                         output int order[8], output int cyc[8]);
    int ng;
    ng = 0;
    for (int i = 0; i < 8; i++) begin order[i] = -1; cyc[i] = 0; end
    @(negedge clk);
    req = req_v;
    for (int c = 0; c < 40 && ng < n; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int j = 0; j < N; j++) if (gnt[j]) order[ng] = j;
        cyc[ng] = c;
        if (ng == 4) chk("rr_q_after4", q, 8'h0F);
        ng++;
        if (ng == n) req = '0;
      end
    end
    chk("grants_collected", ng, n);
    @(negedge clk);
  endtask

  initial begin
    int order[8];
    int cyc[8];
    int exp_rr[8];
    int exp_pr[3];
    rst = 1'b1; en = 1'b0; req = '0; mask = '0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;
    en = 1'b1;
    // reset state
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_q", q, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", apply_cnt, 16'h0000);

    // single requester
    do_op(1, 8'hA5);
    chk("single_q", q, 8'hA5);
    chk("single_done", done, 1'b1);
    chk("single_cnt", apply_cnt, 16'd1);
    chk("single_gnt_low", gnt, 4'h0);
    do_op(1, 8'hA5);
    chk("repeat_q", q, 8'h00);
    chk("repeat_cnt", apply_cnt, 16'd2);

    // reset in the middle of an APPLY
    do_op(0, 8'h0F);
    chk("pre_rst_q", q, 8'h0F);
    @(negedge clk);
    req = 4'b0001; mask[0 +: W] = 8'hFF;
    @(negedge clk);
    chk("midrst_gnt", gnt, 4'b0001);
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk("midrst_q", q, 8'h00);
    chk("midrst_cnt", apply_cnt, 16'h0000);
    chk("midrst_gnt0", gnt, 4'h0);
    chk("midrst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_q_stays", q, 8'h00);

    // round-robin, all requesting
    mask = {8'h08, 8'h04, 8'h02, 8'h01};
    collect(4'b1111, 8, order, cyc);
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) chk("rr_order", order[i], exp_rr[i]);
    for (int i = 1; i < 8; i++) chk("rr_spacing", cyc[i] - cyc[i-1], 2);
    chk("rr_q_after8", q, 8'h00);
    chk("rr_cnt", apply_cnt, 16'd8);

    // enable gating
    en = 1'b0; req = 4'b0100;
    repeat (5) begin
      @(negedge clk);
      chk("gate_gnt", gnt, 4'h0);
      chk("gate_q", q, 8'h00);
    end
    en = 1'b1;
    @(negedge clk);
    chk("gate_release_gnt", gnt, 4'b0100);
    req = '0;
    @(negedge clk);
    chk("gate_q_after", q, 8'h04);
    chk("gate_done", done, 1'b1);

    // zero mask and counter wrap
    @(negedge clk);
    force dut.apply_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1 release dut.apply_cnt;
    @(negedge clk);
    chk("preload_cnt", apply_cnt, 16'hFFFE);
    do_op(3, 8'h00);
    chk("zero1_q", q, 8'h04);
    chk("zero1_cnt", apply_cnt, 16'hFFFF);
    chk("zero1_done", done, 1'b1);
    do_op(3, 8'h00);
    chk("zero2_q", q, 8'h04);
    chk("wrap_cnt", apply_cnt, 16'h0000);
    chk("wrap_done", done, 1'b1);

    // req 1001 held for 3 operations
    mask = {8'h08, 8'h04, 8'h02, 8'h01};
    collect(4'b1001, 3, order, cyc);
`ifdef TOGGLE_BANK_ARB_FIXED_PRIO_EN
    exp_pr = '{0, 0, 0};
`else
    exp_pr = '{0, 3, 0};
`endif
    for (int i = 0; i < 3; i++) chk("prio_order", order[i], exp_pr[i]);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
